// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH clocks per result.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q, sum_q;
    logic [WIDTH-1:0]   a_d, b_d, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, cout_q, busy_q, done_q;
    logic               fa_s, fa_co, last_shift;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q;
`endif

    full_adder u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    assign a_d        = a_q >> 1;
    assign b_d        = b_q >> 1;
    assign sum_d      = {fa_s, sum_q[WIDTH-1:1]};
    assign cnt_d      = cnt_q + CNT_W'(1);
    assign last_shift = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    sum_q   <= sum_d;
                    carry_q <= fa_co;
                    cnt_q   <= cnt_d;
                    // carry_q here is the carry into the MSB on the final shift
                    if (last_shift) begin
                        cout_q  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_q   <= carry_q ^ fa_co;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder (WIDTH=8) against an arithmetic model.
// Honours SERIAL_ADDER_OVF_EN when the design is built with it.

module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int nvec = 0;
    int nerr = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [8:0] model_sum(input logic [7:0] x, input logic [7:0] y, input logic c);
        int s;
        s = int'(x) + int'(y) + int'(c);
        return s[8:0];
    endfunction

    function automatic logic model_ovf(input logic [7:0] x, input logic [7:0] y, input logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s > 127) || (s < -128);
    endfunction

    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_c);
        int bcnt;
        logic [8:0] e;
        e = model_sum(op_a, op_b, op_c);
        @(negedge clk);
        start = 1'b1; a = op_a; b = op_b; cin = op_c;
        @(negedge clk);
        start = 1'b0;
        bcnt = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (busy) bcnt++;
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            @(negedge clk);
        end
        check("busy_cycles", bcnt, 8);
        check("done", {31'd0, done}, 1);
        check("busy_in_done", {31'd0, busy}, 0);
        check("sum", {24'd0, sum}, {24'd0, e[7:0]});
        check("cout", {31'd0, cout}, {31'd0, e[8]});
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, model_ovf(op_a, op_b, op_c)});
`endif
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 0);
        check("sum_hold", {24'd0, sum}, {24'd0, e[7:0]});
        check("cout_hold", {31'd0, cout}, {31'd0, e[8]});
    endtask

    initial begin
        int dcnt;
        int nd;
        int didx[4];
        logic [7:0] sum_seen;
        logic cout_seen;

        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_sum", {24'd0, sum}, 0);
        check("rst_cout", {31'd0, cout}, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op(8'h0F, 8'h01, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1);
        run_op(8'h7F, 8'h01, 1'b0);
        run_op(8'h80, 8'h80, 1'b0);

        // start during SHIFT is ignored
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0; sum_seen = '0; cout_seen = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (done) begin
                dcnt++; sum_seen = sum; cout_seen = cout;
            end
            @(negedge clk);
        end
        check("ign_done_count", dcnt, 1);
        check("ign_sum", {24'd0, sum_seen}, 32'h46);
        check("ign_cout", {31'd0, cout_seen}, 0);

        // back-to-back with start held high
        start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
        nd = 0;
        for (int k = 0; k < 60 && nd < 4; k++) begin
            @(negedge clk);
            if (done) begin
                didx[nd] = k;
                nd++;
                check("b2b_sum", {24'd0, sum}, 32'h03);
                check("b2b_cout", {31'd0, cout}, 0);
            end
        end
        check("b2b_count", nd, 4);
        for (int i = 1; i < 4; i++) check("b2b_period", didx[i] - didx[i-1], 9);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // asynchronous reset mid-operation, start held during reset
        run_op(8'h3C, 8'h21, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 8'h77; b = 8'h11; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1; start = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 0);
        check("arst_done", {31'd0, done}, 0);
        check("arst_sum", {24'd0, sum}, 0);
        check("arst_cout", {31'd0, cout}, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("arst_ovf", {31'd0, ovf}, 0);
`endif
        @(negedge clk);
        check("arst_start_ignored", {31'd0, busy}, 0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) dcnt++;
            @(negedge clk);
        end
        check("arst_no_done", dcnt, 0);
        run_op(8'h05, 8'h03, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
